// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU select codes and FSM state type for the ALU op sequencer.
package alu_seq_pkg;

  localparam int DATA_W   = 5;
  localparam int RF_DEPTH = 4;

  localparam logic [2:0] OP_GTMASK  = 3'b000;
  localparam logic [2:0] OP_MAX     = 3'b001;
  localparam logic [2:0] OP_ROTL    = 3'b010;
  localparam logic [2:0] OP_SHR2    = 3'b011;
  localparam logic [2:0] OP_XNOR    = 3'b100;
  localparam logic [2:0] OP_NAND    = 3'b101;
  localparam logic [2:0] OP_LOAD    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  localparam logic [3:0] SEL_GTMASK = 4'b0000;
  localparam logic [3:0] SEL_MAX    = 4'b0001;
  localparam logic [3:0] SEL_ROTL   = 4'b0101;
  localparam logic [3:0] SEL_SHR2   = 4'b0111;
  localparam logic [3:0] SEL_XNOR   = 4'b1100;
  localparam logic [3:0] SEL_NAND   = 4'b1101;
  localparam logic [3:0] SEL_CONST  = 4'b1111;

  // Parked select; issuing any real op must toggle alu_s away from this.
  localparam logic [3:0] S_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } state_t;

  function automatic logic [3:0] encode_op(input logic [2:0] op);
    logic [3:0] sel;
    case (op)
      OP_GTMASK: sel = SEL_GTMASK;
      OP_MAX:    sel = SEL_MAX;
      OP_ROTL:   sel = SEL_ROTL;
      OP_SHR2:   sel = SEL_SHR2;
      OP_XNOR:   sel = SEL_XNOR;
      OP_NAND:   sel = SEL_NAND;
      default:   sel = SEL_CONST;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x5-bit register file: three combinational read ports, one synchronous write port.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  input  logic [1:0]        raddr_dbg,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_dbg
);

  logic [DATA_W-1:0] mem [RF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = mem[raddr_a];
  assign rdata_b   = mem[raddr_b];
  assign rdata_dbg = mem[raddr_dbg];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven initiator for the 5-bit select-coded ALU: reads operands,
// drives the ALU for one settle cycle, captures and writes back the result.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   ST_IDLE    | cmd_ready=1, waiting for a command
//   ST_ISSUE   | operands/select applied, ALU settling
//   ST_CAPTURE | result sampled into rsp regs, rf written (not ILLEGAL)
//   ST_RESP    | rsp_valid=1, waiting for rsp_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_dst,
  input  logic [1:0]  cmd_srca,
  input  logic [1:0]  cmd_srcb,
  input  logic [4:0]  cmd_imm,
  output logic [4:0]  alu_a,
  output logic [4:0]  alu_b,
  output logic [3:0]  alu_s,
  input  logic [4:0]  alu_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_data,
  output logic [1:0]  rsp_dst,
  output logic        rsp_err,
  input  logic [1:0]  dbg_addr,
  output logic [4:0]  dbg_data
);

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [1:0]  dst_q;
  logic [4:0]  imm_q;
  logic [4:0]  rf_a, rf_b;
  logic [4:0]  result;
  logic        accept;
  logic        rf_we;

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = cmd_ready && cmd_valid;
  assign result    = (op_q == OP_LOAD) ? imm_q : alu_y;
  assign rf_we     = (state == ST_CAPTURE) && (op_q != OP_ILLEGAL);

  alu_seq_regfile u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (dst_q),
    .wdata     (result),
    .raddr_a   (cmd_srca),
    .raddr_b   (cmd_srcb),
    .raddr_dbg (dbg_addr),
    .rdata_a   (rf_a),
    .rdata_b   (rf_b),
    .rdata_dbg (dbg_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cmd_valid) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      rsp_data <= '0;
      rsp_dst  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Operands are read here, so a dst that is also a source sees the old value.
        alu_a <= rf_a;
        alu_b <= rf_b;
        alu_s <= encode_op(cmd_op);
        op_q  <= cmd_op;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
      end else if (state == ST_CAPTURE) begin
        alu_s    <= S_IDLE;
        rsp_data <= result;
        rsp_dst  <= dst_q;
        rsp_err  <= (op_q == OP_ILLEGAL);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed table, multi-cycle
// corner sequences and randomized commands against a reference model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
  logic [4:0] cmd_imm;
  logic [4:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_s;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [4:0] rsp_data;
  logic [1:0] rsp_dst;
  logic [1:0] dbg_addr;
  logic [4:0] dbg_data;

  int n_pass = 0;
  int n_total = 0;
  logic [4:0] mrf [4];

  always #10 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_dst(rsp_dst), .rsp_err(rsp_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU, keyed on select code.
  always_comb begin
    alu_y = 5'd0;
    case (alu_s)
      4'b0000: alu_y = (alu_a > alu_b) ? 5'd31 : 5'd0;
      4'b0001: alu_y = (alu_a > alu_b) ? alu_a : alu_b;
      4'b0101: alu_y = {alu_b[3:0], alu_b[4]};
      4'b0111: alu_y = alu_a >> 2;
      4'b1100: alu_y = ~(alu_a ^ alu_b);
      4'b1101: alu_y = ~(alu_a & alu_b);
      4'b1111: alu_y = 5'd6;
      default: alu_y = 5'd0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int sel_of(input logic [2:0] op);
    case (op)
      3'd0: return 4'b0000;
      3'd1: return 4'b0001;
      3'd2: return 4'b0101;
      3'd3: return 4'b0111;
      3'd4: return 4'b1100;
      3'd5: return 4'b1101;
      default: return 4'b1111;
    endcase
  endfunction

  // Reference result from opcode semantics with plain arithmetic.
  function automatic logic [4:0] ref_result(input logic [2:0] op, input int a, input int b, input int imm);
    case (op)
      3'd0: return (a > b) ? 5'd31 : 5'd0;
      3'd1: return 5'((a > b) ? a : b);
      3'd2: return 5'(((b * 2) + (b / 16)) % 32);
      3'd3: return 5'(a / 4);
      3'd4: return 5'(31 - (a ^ b));
      3'd5: return 5'(31 - (a & b));
      3'd6: return 5'(imm);
      default: return 5'd6;
    endcase
  endfunction

  task automatic check_rf(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbg_addr = 2'(r);
      #1;
      chk(tag, dbg_data, mrf[r]);
    end
  endtask

  // One full command; hold = cycles of rsp backpressure with ignored cmd pulses.
  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [4:0] imm, input int hold,
                       output logic [4:0] d, output logic e, output logic [1:0] ds);
    int n, lat;
    @(negedge clk);
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("issue_sel", alu_s, sel_of(op));
    chk("issue_a", alu_a, mrf[sa]);
    chk("issue_b", alu_b, mrf[sb]);
    chk("issue_busy", cmd_ready, 0);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 20);
    chk("latency", lat, 2);
    chk("resp_sel", alu_s, 4'b1111);
    d = rsp_data; e = rsp_err; ds = rsp_dst;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_op = 3'd6; cmd_dst = ~dst; cmd_imm = 5'd31;
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, d);
      chk("bp_dst", rsp_dst, ds);
      chk("bp_err", rsp_err, e);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("ready_after_rsp", cmd_ready, 1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] dst, sa, sb;
    logic [4:0] imm;
    logic [4:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [4:0] d, exp_d;
    logic       e;
    logic [1:0] ds;
    int acc[$];
    logic seen;

    tbl[0] = '{3'd6, 2'd0, 2'd0, 2'd0, 5'd22, 5'd22, 1'b0};  // LOAD r0=22
    tbl[1] = '{3'd6, 2'd1, 2'd0, 2'd0, 5'd13, 5'd13, 1'b0};  // LOAD r1=13
    tbl[2] = '{3'd1, 2'd2, 2'd0, 2'd1, 5'd0,  5'd22, 1'b0};  // MAX
    tbl[3] = '{3'd7, 2'd3, 2'd0, 2'd1, 5'd9,  5'd6,  1'b1};  // ILLEGAL, r3 stays 0
    tbl[4] = '{3'd0, 2'd3, 2'd0, 2'd1, 5'd0,  5'd31, 1'b0};  // GTMASK r0,r1
    tbl[5] = '{3'd0, 2'd3, 2'd1, 2'd0, 5'd0,  5'd0,  1'b0};  // GTMASK r1,r0
    tbl[6] = '{3'd5, 2'd2, 2'd0, 2'd1, 5'd0,  5'd27, 1'b0};  // NAND
    tbl[7] = '{3'd4, 2'd2, 2'd0, 2'd1, 5'd0,  5'd4,  1'b0};  // XNOR
    tbl[8] = '{3'd3, 2'd3, 2'd0, 2'd1, 5'd0,  5'd5,  1'b0};  // SHR2 A=r0
    tbl[9] = '{3'd2, 2'd2, 2'd0, 2'd1, 5'd0,  5'd26, 1'b0};  // ROTL B=r1

    for (int r = 0; r < 4; r++) mrf[r] = 5'd0;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; dbg_addr = 2'd0;
    cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; cmd_imm = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_s", alu_s, 4'b1111);
    chk("rst_alu_a", alu_a, 0);
    check_rf("rst_rf");

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].imm, (i == 2) ? 3 : 0, d, e, ds);
      chk("tbl_data", d, tbl[i].exp_data);
      chk("tbl_err", e, tbl[i].exp_err);
      chk("tbl_dst", ds, tbl[i].dst);
      if (!tbl[i].exp_err) mrf[tbl[i].dst] = tbl[i].exp_data;
      check_rf("tbl_rf");
    end

    // Self-update: operand read precedes write-back.
    issue(3'd6, 2'd1, 2'd0, 2'd0, 5'd13, 0, d, e, ds);
    mrf[1] = 5'd13;
    issue(3'd1, 2'd1, 2'd1, 2'd0, 5'd0, 0, d, e, ds);
    chk("self_update", d, 22);
    mrf[1] = 5'd22;
    check_rf("self_rf");

    // Back-to-back with cmd_valid held and rsp_ready held high.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_dst = 2'd3; cmd_imm = 5'd17;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (cmd_ready) acc.push_back(c);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_count", acc.size(), 5);
    for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", acc[i] - acc[i-1], 4);
    mrf[3] = 5'd17;
    check_rf("b2b_rf");

    // Reset during ISSUE aborts the command.
    @(negedge clk);
    cmd_op = 3'd6; cmd_dst = 2'd2; cmd_imm = 5'd9; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_rsp_dst", rsp_dst, 0);
    chk("mid_rst_rsp_err", rsp_err, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_s", alu_s, 4'b1111);
    for (int r = 0; r < 4; r++) mrf[r] = 5'd0;
    check_rf("mid_rst_rf");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen = seen | rsp_valid; end
    chk("mid_rst_no_rsp", seen, 0);
    check_rf("mid_rst_rf_after");

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [1:0] dst, sa, sb;
      logic [4:0] imm;
      op  = 3'($urandom_range(0, 7));
      dst = 2'($urandom_range(0, 3));
      sa  = 2'($urandom_range(0, 3));
      sb  = 2'($urandom_range(0, 3));
      imm = 5'($urandom_range(0, 31));
      exp_d = ref_result(op, mrf[sa], mrf[sb], imm);
      issue(op, dst, sa, sb, imm, $urandom_range(0, 2), d, e, ds);
      chk("rnd_data", d, exp_d);
      chk("rnd_err", e, (op == 3'd7) ? 1 : 0);
      chk("rnd_dst", ds, dst);
      if (op != 3'd7) mrf[dst] = exp_d;
      check_rf("rnd_rf");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-driven initiator for the team's 5-bit combinational ALU (select-coded `S`, operands `A`/`B`, result `Alu`). The block accepts 3-bit opcodes over a valid/ready handshake and encodes each to the ALU's 4-bit select. It reads operands from an internal 4×5-bit register file, drives the ALU, captures the result and writes it back. Each outcome is reported on a valid/ready response channel. It sits between a test/control master and one ALU instance.

## Interface
- No parameters: data width 5, register file depth 4, fixed.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 3: opcode (see Operation).
- `cmd_dst` in 2: destination register.
- `cmd_srca`, `cmd_srcb` in 2 each: operand register indices.
- `cmd_imm` in 5: immediate, used by LOAD only.
- `alu_a`, `alu_b` out 5 each: ALU operands.
- `alu_s` out 4: ALU select.
- `alu_y` in 5: ALU result, combinational from `alu_a`/`alu_b`/`alu_s`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out 5: captured result.
- `rsp_dst` out 2: destination of the command.
- `rsp_err` out 1: illegal opcode.
- `dbg_addr` in 2: debug read index.
- `dbg_data` out 5: combinational `rf[dbg_addr]`.

## Operation
- Opcode to `alu_s` mapping:
  - 000 GTMASK → 0000
  - 001 MAX → 0001
  - 010 ROTL(B) → 0101
  - 011 SHR2(A) → 0111
  - 100 XNOR → 1100
  - 101 NAND → 1101
  - 110 LOAD → 1111; result is `cmd_imm`, `alu_y` is ignored.
  - 111 ILLEGAL → 1111; result is `alu_y`, which should be 6. Sets `rsp_err`; the register file is not written.
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, go to ISSUE.
  - ISSUE: go to CAPTURE unconditionally.
  - CAPTURE: write `rf[dst]` unless ILLEGAL, then go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Operand read happens at accept: `alu_a`=`rf[srca]`, `alu_b`=`rf[srcb]`, registered. A read of a register equal to `dst` returns the old value.
- `alu_s` equals the encoded select during ISSUE and CAPTURE. It is 4'b1111 in IDLE and RESP, so every non-LOAD/ILLEGAL issue produces a transition on `alu_s`; the ALU's sensitivity relies on this.
- `alu_a`/`alu_b` hold their values until the next accept.
- Arithmetic is done only inside the ALU. The block adds no widening; all values are 5-bit unsigned.

## Timing
- E0 is the accept edge, where `cmd_valid`&`cmd_ready`. At E0:
  - operands, select, dst and op are registered;
  - state becomes ISSUE;
  - `cmd_ready` drops.
- E1 is the end of ISSUE. State becomes CAPTURE; the ALU has had one full cycle to settle.
- At E2:
  - `alu_y` (or `cmd_imm`, latched at E0) is sampled into `rsp_data`;
  - `rf` is written;
  - `rsp_valid`=1 from E2.
- Minimum latency from accept to `rsp_valid` is 2 cycles. Minimum command spacing is 4 cycles.
- Response channel:
  - `rsp_valid`, `rsp_data`, `rsp_dst` and `rsp_err` are stable while `rsp_valid`&!`rsp_ready`.
  - The handshake edge returns the block to IDLE, and `cmd_ready`=1 the next cycle.
- `cmd_*` inputs are don't-care outside the accept edge. `cmd_valid` asserted outside IDLE is ignored, not queued.
- Reset values:
  - state IDLE, so `cmd_ready`=1;
  - `rsp_valid`, `rsp_err`, `rsp_data`, `rsp_dst` all 0;
  - `alu_a`=`alu_b`=0;
  - `alu_s`=4'b1111;
  - all `rf` entries 0.
- Reset mid-operation, in any state, aborts the command. No response is produced and no `rf` write occurs if reset asserts before E2.

## Structure
- Package `alu_seq_pkg` holds:
  - opcode localparams (OP_GTMASK … OP_ILLEGAL);
  - ALU select codes;
  - `S_IDLE`=4'b1111;
  - the FSM state enum.
- Sub-module `alu_seq_regfile`: 4×5-bit storage with asynchronous reset to zero. It has three combinational read ports (srca, srcb, dbg) and one synchronous write port (`we`, `waddr`, `wdata`).
- The top level contains the FSM, the op encoder, the operand/select registers and the response registers.

## Test plan
- Load and max: LOAD r0=22, then LOAD r1=13, then MAX r2←r0,r1.
  - Each response has `rsp_err`=0.
  - The MAX response has `rsp_data`=22 and `dbg_data`(r2)=22.
  - `alu_s` shows 0001 only during ISSUE/CAPTURE.
- Compare and logic ops, with r0=22 and r1=13:
  - GTMASK(r0,r1) → 31;
  - GTMASK(r1,r0) → 0;
  - NAND → 27;
  - XNOR → 4;
  - SHR2(A=r0) → 5;
  - ROTL(B=r1) → 26.
  - All results are written to the named `dst`.
- Illegal opcode: op=111, dst=r3 → `rsp_err`=1, `rsp_data`=6, and r3 is unchanged (0).
- Backpressure: hold `rsp_ready`=0 for 3 cycles after `rsp_valid`.
  - `rsp_*` stays stable; `cmd_ready`=0; `cmd_valid` pulses are ignored.
  - Release → `cmd_ready`=1 next cycle.
- Self-update: r1=13, then MAX r1←r1,r0 → `rsp_data`=22, because the operand is read before write.
  - Back-to-back commands, with `cmd_valid` held high, are spaced exactly 4 cycles apart.
- Reset mid-op: drop `rst_n` during ISSUE → all outputs are at reset values immediately, no response appears, and every `rf` entry reads 0.
